// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the rv64I fetch front end.
package fetch_pkg;
  localparam int XLEN = 64;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam int PC_STEP_DEFAULT = 4;
  typedef enum logic [2:0] {REQ, WAIT, HOLD, DROP, TRAP} fetch_state_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry {pc, inst} capture register for a response decode cannot take yet.
module fetch_hold_buf import fetch_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o
);
  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end
  end
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: fetch PC owner, single-outstanding imem requester and redirect/flush handler.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets trap instead of being aligned down.
module fetch_redirect_unit import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_i_need_jump,
  input  logic [XLEN-1:0]   fetch_i_jump_pc,
  input  logic              fetch_i_stall,
  output logic              fetch_o_imem_req_valid,
  input  logic              fetch_i_imem_req_ready,
  output logic [XLEN-1:0]   fetch_o_imem_addr,
  input  logic              fetch_i_imem_resp_valid,
  input  logic [INST_W-1:0] fetch_i_imem_resp_inst,
  output logic              fetch_o_valid,
  output logic [XLEN-1:0]   fetch_o_pc,
  output logic [INST_W-1:0] fetch_o_inst,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic              fetch_o_misalign,
`endif
  output logic              fetch_o_flush
);
  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, pc_req_q, pc_req_d, buf_pc;
  logic [INST_W-1:0] buf_inst;
  logic              buf_load, buf_clear, buf_valid, outstanding;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic              trap_q, trap_d, stale_q, stale_d;
`endif
  fetch_hold_buf u_buf (
    .clk(clk), .rst(rst), .load_i(buf_load), .clear_i(buf_clear),
    .pc_i(pc_req_q), .inst_i(fetch_i_imem_resp_inst),
    .valid_o(buf_valid), .pc_o(buf_pc), .inst_o(buf_inst)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pc_req_d = pc_req_q;
    fetch_o_imem_req_valid = 1'b0;
    fetch_o_imem_addr = '0;
    fetch_o_valid = 1'b0;
    fetch_o_pc = '0;
    fetch_o_inst = '0;
    fetch_o_flush = 1'b0;
    buf_load = 1'b0;
    buf_clear = 1'b0;
    outstanding = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    trap_d = trap_q;
    stale_d = stale_q;
    fetch_o_misalign = 1'b0;
`endif
    if (!rst) begin
      fetch_o_imem_addr = pc_q;
      case (state_q)
        REQ: begin
          fetch_o_imem_req_valid = 1'b1;
          if (fetch_i_imem_req_ready) begin
            pc_req_d = pc_q;
            state_d = WAIT;
          end
        end
        WAIT: if (fetch_i_imem_resp_valid) begin
          if (!fetch_i_stall) begin
            fetch_o_valid = 1'b1;
            fetch_o_pc = pc_req_q;
            fetch_o_inst = fetch_i_imem_resp_inst;
            pc_d = pc_q + XLEN'(PC_STEP);
            state_d = REQ;
          end else begin
            buf_load = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          fetch_o_valid = buf_valid;
          fetch_o_pc = buf_pc;
          fetch_o_inst = buf_inst;
          if (!fetch_i_stall) begin
            buf_clear = 1'b1;
            pc_d = pc_q + XLEN'(PC_STEP);
            state_d = REQ;
          end
        end
        DROP: state_d = fetch_i_imem_resp_valid ? REQ : DROP;
`ifdef FETCH_MISALIGN_CHECK_EN
        TRAP: begin
          fetch_o_valid = trap_q;
          fetch_o_misalign = trap_q;
          fetch_o_pc = trap_q ? pc_q : '0;
          trap_d = trap_q && fetch_i_stall;
          stale_d = stale_q && !fetch_i_imem_resp_valid;
        end
`endif
        default: state_d = REQ;
      endcase
      if (fetch_i_need_jump) begin
        // A request still in flight must have its response swallowed by DROP.
        outstanding = ((state_q == DROP || state_q == WAIT) && !fetch_i_imem_resp_valid) ||
                      (state_q == REQ && fetch_i_imem_req_ready);
        fetch_o_flush = 1'b1;
        fetch_o_valid = 1'b0;
        fetch_o_pc = '0;
        fetch_o_inst = '0;
        buf_load = 1'b0;
        buf_clear = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        outstanding = outstanding || (state_q == TRAP && stale_q && !fetch_i_imem_resp_valid);
        fetch_o_misalign = 1'b0;
        pc_d = fetch_i_jump_pc;
        trap_d = fetch_i_jump_pc[1:0] != 2'b00;
        stale_d = trap_d && outstanding;
        state_d = trap_d ? TRAP : (outstanding ? DROP : REQ);
`else
        pc_d = fetch_i_jump_pc & ~XLEN'(3);
        state_d = outstanding ? DROP : REQ;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      pc_req_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      trap_q   <= 1'b0;
      stale_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_req_q <= pc_req_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      trap_q   <= trap_d;
      stale_q  <= stale_d;
`endif
    end
  end
endmodule
